// File: rtl/apb_master_arb.sv
// APB master serving two requesters through a round-robin arbiter.
// One transfer at a time: IDLE -> SETUP -> ACCESS -> IDLE. The IDLE cycle
// after completion carries the ack pulse. An ACCESS phase that runs TIMEOUT
// cycles without PREADY is aborted with err=1 and rdata=32'hDEAD_BEEF.
module apb_master_arb #(
   parameter int TIMEOUT = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic        wr0,
   input  logic        wr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err,
   output logic [31:0] rdata,
   output logic [3:0]  PADDR,
   output logic        PWRITE,
   output logic        PENABLE,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSEL,
   input  logic [31:0] PRDATA0,
   input  logic [31:0] PRDATA1,
   input  logic [31:0] PRDATA2,
   input  logic [31:0] PRDATA3,
   input  logic        PREADY0,
   input  logic        PREADY1,
   input  logic        PREADY2,
   input  logic        PREADY3
);

   localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [31:0]      ABORT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [3:0]       paddr_q,  paddr_d;
   logic [1:0]       sel_q,    sel_d;
   logic             pwrite_q, pwrite_d;
   logic [31:0]      pwdata_q, pwdata_d;
   logic             gnt_id_q, gnt_id_d;
   logic             last_q,   last_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [1:0]       ack_q,    ack_d;
   logic             err_q,    err_d;
   logic [31:0]      rdata_q,  rdata_d;

   logic [1:0]  elig;
   logic        win_id;
   logic [31:0] sel_prdata;
   logic        sel_pready;

   // Only addr[3:0] and addr[13:12] take part in the APB transfer.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr0[31:14], addr0[11:4], addr1[31:14], addr1[11:4]};

   // Return path: only the selected slave's PREADY/PRDATA are looked at.
   always_comb begin
      sel_prdata = PRDATA0;
      sel_pready = PREADY0;
      case (sel_q)
         2'd0: begin sel_prdata = PRDATA0; sel_pready = PREADY0; end
         2'd1: begin sel_prdata = PRDATA1; sel_pready = PREADY1; end
         2'd2: begin sel_prdata = PRDATA2; sel_pready = PREADY2; end
         2'd3: begin sel_prdata = PRDATA3; sel_pready = PREADY3; end
         default: ;
      endcase
   end

   // Round-robin pick; the requester being acked this cycle is not eligible.
   always_comb begin
      elig = {req1 & ~ack_q[1], req0 & ~ack_q[0]};
      if (elig == 2'b11) win_id = ~last_q;
      else               win_id = elig[1];
   end

   // Next-state and datapath update for the transfer FSM.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves a variable
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      paddr_d  = paddr_q;
      sel_d    = sel_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      gnt_id_d = gnt_id_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      ack_d    = 2'b00;

      case (state_q)
         IDLE: begin
            if (elig != 2'b00) begin
               gnt_id_d = win_id;
               last_d   = win_id;
               paddr_d  = win_id ? addr1[3:0]   : addr0[3:0];
               sel_d    = win_id ? addr1[13:12] : addr0[13:12];
               pwrite_d = win_id ? wr1          : wr0;
               pwdata_d = win_id ? wdata1       : wdata0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (sel_pready) begin
               if (!pwrite_q) rdata_d = sel_prdata;
               err_d           = 1'b0;
               ack_d[gnt_id_q] = 1'b1;
               cnt_d           = '0;
               state_d         = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d         = ABORT_DATA;
               err_d           = 1'b1;
               ack_d[gnt_id_q] = 1'b1;
               cnt_d           = '0;
               state_d         = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge PCLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (PRESET) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         sel_q    <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         gnt_id_q <= 1'b0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         ack_q    <= 2'b00;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         sel_q    <= sel_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         gnt_id_q <= gnt_id_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign PSEL    = (state_q == SETUP || state_q == ACCESS) ? (4'b0001 << sel_q) : 4'b0000;
   assign PENABLE = (state_q == ACCESS);
   assign PADDR   = paddr_q;
   assign PWRITE  = pwrite_q;
   assign PWDATA  = pwdata_q;
   assign ack0    = ack_q[0];
   assign ack1    = ack_q[1];
   assign err     = err_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_apb_master_arb;

   localparam int TIMEOUT = 16;

   logic        PCLK;
   logic        PRESET;
   logic [1:0]  req_v;
   logic [31:0] addr_v  [2];
   logic [1:0]  wr_v;
   logic [31:0] wdata_v [2];
   logic        ack0, ack1, err;
   logic [31:0] rdata;
   logic [3:0]  PADDR, PSEL;
   logic        PWRITE, PENABLE;
   logic [31:0] PWDATA;
   logic [31:0] prdata_v [4];
   logic [3:0]  pready_v;

   apb_master_arb #(.TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0(req_v[0]), .req1(req_v[1]),
      .addr0(addr_v[0]), .addr1(addr_v[1]),
      .wr0(wr_v[0]), .wr1(wr_v[1]),
      .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
      .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
      .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA), .PSEL(PSEL),
      .PRDATA0(prdata_v[0]), .PRDATA1(prdata_v[1]), .PRDATA2(prdata_v[2]), .PRDATA3(prdata_v[3]),
      .PREADY0(pready_v[0]), .PREADY1(pready_v[1]), .PREADY2(pready_v[2]), .PREADY3(pready_v[3])
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // One expected transfer: who, what, when it is granted and acked.
   typedef struct {
      logic        id;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          g;
      int          a;
      logic        to;
      logic [31:0] rd;
   } xfer_t;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   xfer_t       cur;
   bit          cur_valid;
   logic        model_last;
   logic [31:0] exp_rdata;

   bit          pend [2];
   logic [31:0] pend_addr [2];
   logic        pend_wr [2];
   logic [31:0] pend_wdata [2];
   bit          auto_en;
   bit          hold_mode;
   int          gap [2];

   int          force_wait;
   bit          force_rd_en;
   logic [31:0] force_rd;
   int          slave_wait [4];
   logic [31:0] slave_rd [4];
   int          acc_cnt [4];
   int          wait_tbl [8] = '{0, 0, 1, 2, 3, 15, 16, 40};

   int          last_ack_cyc [2];
   logic [31:0] last_ack_rdata;
   logic        last_ack_err;
   logic [1:0]  ack_hist [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [41:0] exp_bus(input xfer_t t, input logic en);
      logic [3:0] onehot;
      onehot = 4'b0001 << t.addr[13:12];
      return {onehot, en, t.addr[3:0], t.wr, t.wdata};
   endfunction

   // One clock cycle: check outputs, move requesters, arbitrate in the model,
   // then let the slave models answer the bus as they see it.
   task automatic step();
      logic [1:0]  ack_obs;
      logic [41:0] bus;
      bit          ack_now;
      logic        ack_id;
      logic [1:0]  elig;
      logic        win;
      int          w;
      int          s;
      logic        rdy;
      @(negedge PCLK);
      cyc++;
      ack_obs = {ack1, ack0};
      bus     = {PSEL, PENABLE, PADDR, PWRITE, PWDATA};
      ack_now = 1'b0;
      ack_id  = 1'b0;

      if (cur_valid && cyc == cur.g + 1)
         check("setup_bus", 64'(bus), 64'(exp_bus(cur, 1'b0)));
      else if (cur_valid && cyc >= cur.g + 2 && cyc < cur.a)
         check("access_bus", 64'(bus), 64'(exp_bus(cur, 1'b1)));
      else
         check("idle_psel_penable", 64'({PSEL, PENABLE}), 64'd0);

      check("ack", 64'(ack_obs), 64'((cur_valid && cyc == cur.a) ? (2'b01 << cur.id) : 2'b00));
      if (cur_valid && cyc == cur.a) begin
         if (cur.to)      exp_rdata = 32'hDEAD_BEEF;
         else if (!cur.wr) exp_rdata = cur.rd;
         check("err", 64'(err), 64'(cur.to));
         check("rdata", 64'(rdata), 64'(exp_rdata));
         ack_now = 1'b1;
         ack_id  = cur.id;
      end
      for (int i = 0; i < 2; i++) if (ack_obs[i]) last_ack_cyc[i] = cyc;
      if (ack_obs != 2'b00) begin
         last_ack_rdata = rdata;
         last_ack_err   = err;
         ack_hist.push_back(ack_obs);
      end

      // Requesters: drop on ack, then request again after a gap.
      for (int i = 0; i < 2; i++) begin
         if (req_v[i] && ack_obs[i]) begin
            req_v[i] = 1'b0;
            gap[i]   = (hold_mode || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
         end else if (!req_v[i]) begin
            if (pend[i]) begin
               req_v[i]   = 1'b1;
               addr_v[i]  = pend_addr[i];
               wr_v[i]    = pend_wr[i];
               wdata_v[i] = pend_wdata[i];
               pend[i]    = 1'b0;
            end else if (auto_en && gap[i] == 0) begin
               req_v[i]   = 1'b1;
               addr_v[i]  = $urandom;
               wr_v[i]    = 1'($urandom_range(0, 1));
               wdata_v[i] = $urandom;
            end else if (gap[i] > 0) begin
               gap[i]--;
            end
         end
      end

      // Reference arbitration: only when no transfer is outstanding.
      if (!cur_valid || cyc >= cur.a) begin
         elig[0] = req_v[0] && !(ack_now && ack_id == 1'b0);
         elig[1] = req_v[1] && !(ack_now && ack_id == 1'b1);
         if (elig != 2'b00) begin
            win        = (elig == 2'b11) ? ~model_last : elig[1];
            model_last = win;
            cur.id     = win;
            cur.addr   = addr_v[win];
            cur.wr     = wr_v[win];
            cur.wdata  = wdata_v[win];
            cur.g      = cyc;
            w          = (force_wait >= 0) ? force_wait : wait_tbl[$urandom_range(0, 7)];
            s          = int'(cur.addr[13:12]);
            slave_wait[s] = w;
            slave_rd[s]   = force_rd_en ? force_rd : $urandom;
            cur.rd     = slave_rd[s];
            cur.to     = (w + 1 > TIMEOUT);
            cur.a      = cyc + 2 + (cur.to ? TIMEOUT : w + 1);
            cur_valid  = 1'b1;
         end
      end

      // Slaves: the addressed one counts wait states; the rest drive noise.
      for (int k = 0; k < 4; k++) begin
         if (PSEL[k] && PENABLE) begin
            rdy         = (acc_cnt[k] == slave_wait[k]);
            pready_v[k] = rdy;
            prdata_v[k] = rdy ? slave_rd[k] : $urandom;
            acc_cnt[k]++;
         end else begin
            acc_cnt[k]  = 0;
            pready_v[k] = 1'($urandom_range(0, 1));
            prdata_v[k] = $urandom;
         end
      end
   endtask

   task automatic apply_reset();
      PRESET    = 1'b1;
      req_v     = 2'b00;
      pend      = '{1'b0, 1'b0};
      gap       = '{0, 0};
      cur_valid = 1'b0;
      @(negedge PCLK);
      cyc++;
      check("rst_bus", 64'({PSEL, PENABLE, PADDR, PWRITE, PWDATA}), 64'd0);
      check("rst_ack", 64'({ack1, ack0}), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      PRESET     = 1'b0;
      model_last = 1'b1;
      exp_rdata  = 32'h0;
   endtask

   task automatic queue_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
      pend[i]       = 1'b1;
      pend_addr[i]  = a;
      pend_wr[i]    = w;
      pend_wdata[i] = d;
   endtask

   task automatic run_until_idle(input int budget, input string tag);
      int k;
      k = 0;
      while ((req_v != 2'b00 || pend[0] || pend[1] || (cur_valid && cyc < cur.a)) && k < budget) begin
         step();
         k++;
      end
      check(tag, 64'(k < budget), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      req_v = 2'b00; wr_v = 2'b00;
      for (int i = 0; i < 2; i++) begin
         addr_v[i] = '0; wdata_v[i] = '0; pend[i] = 1'b0; gap[i] = 0; last_ack_cyc[i] = -1;
      end
      for (int k2 = 0; k2 < 4; k2++) begin
         prdata_v[k2] = '0; pready_v[k2] = 1'b0; acc_cnt[k2] = 0; slave_wait[k2] = 0; slave_rd[k2] = '0;
      end
      auto_en = 1'b0; hold_mode = 1'b0; force_wait = -1; force_rd_en = 1'b0; force_rd = '0;
      cur_valid = 1'b0; model_last = 1'b1; exp_rdata = '0;

      apply_reset();

      // Single write to slave 1 with two wait states.
      force_wait = 2;
      queue_req(0, 32'h0000_1004, 1'b1, 32'h0000_00A5);
      run_until_idle(50, "drain_write");
      check("write_err", 64'(last_ack_err), 64'd0);

      // Simultaneous requests straight after reset, zero-wait slaves.
      apply_reset();
      force_wait = 0;
      last_ack_cyc = '{-1, -1};
      queue_req(0, 32'h0000_1004, 1'b1, 32'h0000_00A5);
      queue_req(1, 32'h0000_3000, 1'b0, 32'h0);
      run_until_idle(50, "drain_contest");
      check("req0_first", 64'(last_ack_cyc[0] >= 0 && last_ack_cyc[0] < last_ack_cyc[1]), 64'd1);
      check("ack_spacing", 64'(last_ack_cyc[1] - last_ack_cyc[0]), 64'd3);

      // Read from slave 3 with two wait states.
      force_wait = 2; force_rd_en = 1'b1; force_rd = 32'h1234_5678;
      queue_req(1, 32'h0000_3000, 1'b0, 32'h0);
      run_until_idle(50, "drain_read");
      check("read_rdata", 64'(last_ack_rdata), 64'h1234_5678);
      check("read_err", 64'(last_ack_err), 64'd0);
      force_rd_en = 1'b0;

      // Slave never ready: abort after TIMEOUT ACCESS cycles.
      force_wait = 100;
      queue_req(0, 32'h0000_2008, 1'b0, 32'h0);
      run_until_idle(60, "drain_timeout");
      check("timeout_len", 64'(last_ack_cyc[0] - cur.g), 64'(TIMEOUT + 2));
      check("timeout_err", 64'(last_ack_err), 64'd1);
      check("timeout_rdata", 64'(last_ack_rdata), 64'hDEAD_BEEF);

      // Requester withdraws its req mid-transfer; the ack still comes.
      force_wait = 3;
      queue_req(0, 32'h0000_0020, 1'b1, 32'hCAFE_0001);
      k = 0;
      do begin step(); k++; end while (PSEL == 4'b0000 && k < 10);
      req_v[0] = 1'b0;
      run_until_idle(50, "drain_withdraw");
      check("withdraw_ack", 64'(last_ack_cyc[0] == cur.a), 64'd1);

      // Reset in the first ACCESS cycle kills the transfer without an ack.
      force_wait = 100;
      queue_req(0, 32'h0000_0010, 1'b0, 32'h0);
      k = 0;
      do begin step(); k++; end while (!PENABLE && k < 10);
      check("reached_access", 64'(PENABLE), 64'd1);
      apply_reset();
      repeat (4) step();
      force_wait = 1;
      queue_req(0, 32'h0000_1000, 1'b0, 32'h0);
      run_until_idle(50, "drain_after_reset");
      check("fresh_err", 64'(last_ack_err), 64'd0);

      // Both requesters asking back to back: grants must alternate.
      force_wait = 0; hold_mode = 1'b1; gap = '{0, 0};
      ack_hist.delete();
      auto_en = 1'b1;
      repeat (40) step();
      auto_en = 1'b0;
      run_until_idle(60, "drain_alternate");
      hold_mode = 1'b0;
      check("alt_count", 64'(ack_hist.size() >= 10), 64'd1);
      for (int i = 1; i < ack_hist.size(); i++)
         check("alternate", 64'(ack_hist[i] != ack_hist[i-1]), 64'd1);

      // Randomized traffic with mixed wait states and timeouts.
      force_wait = -1;
      auto_en = 1'b1;
      repeat (1500) step();
      auto_en = 1'b0;
      run_until_idle(200, "drain_random");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
